// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default register-index width, the flush NOP and a watchdog width helper.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2
  } hz_state_e;

  localparam int DEFAULT_REG_ADDR_W = 5;

  // addi x0, x0, 0 -- what a flushed fetch/decode register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Bits needed to count up to 'limit'; a disabled watchdog still gets one bit.
  function automatic int wd_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Pure combinational load-use comparator: a load in execute whose destination
// is read by the instruction currently in decode.
module pipeline_hazard_controller_hazard_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = uses_rs1 && (rs1 == rd);
  assign rs2_match = uses_rs2 && (rs2 == rd);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hazard = mem_read && (rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the in-order pipeline registers and PC.
// Optional macro HAZARD_PERF_COUNTERS_EN adds stall/flush/load-use counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  icache_ready,
  input  logic                  dcache_req,
  input  logic                  dcache_ready,
  output logic                  pc_write_en,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_hold,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_hold,
  output logic                  icache_abort,
`ifdef HAZARD_PERF_COUNTERS_EN
  output logic [WORD_SIZE-1:0]  perf_stall_cycles,
  output logic [WORD_SIZE-1:0]  perf_flushes,
  output logic [WORD_SIZE-1:0]  perf_load_use,
`endif
  output logic                  timeout_err
);

  localparam int              WD_W     = wd_width(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

  hz_state_e       state;
  hz_state_e       state_next;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_inc;
  logic            load_use;
  logic            dmiss;
  logic            freeze;
  logic            fetch_wait;

  pipeline_hazard_controller_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .rd       (ex_rd),
    .mem_read (ex_mem_read),
    .hazard   (load_use)
  );

  assign dmiss      = dcache_req && !dcache_ready;
  assign freeze     = (state == ST_DWAIT) || ((state == ST_RUN) && dmiss);
  assign fetch_wait = (state == ST_IWAIT) || ((state == ST_RUN) && !icache_ready);

  // Saturates at the limit so a long wait can never wrap back under it.
  assign wd_inc = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + WD_W'(1);

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // sample pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == ST_RUN) begin
        wd_cnt <= '0;
      end else if (state != ST_RUN) begin
        wd_cnt <= wd_inc;
        if ((MEM_TIMEOUT != 0) && (wd_inc == WD_LIMIT)) timeout_err <= 1'b1;
      end
    end
  end

  // NOTE: defaults are assigned first so every path drives every variable;
  // a missing branch assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN: begin
        if (dmiss)              state_next = ST_DWAIT;
        else if (!icache_ready) state_next = ST_IWAIT;
      end
      ST_DWAIT: if (dcache_ready) state_next = ST_RUN;
      ST_IWAIT: if (icache_ready || ex_branch_taken) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_write_en  = 1'b1;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    icache_abort = 1'b0;
    if (!rst_n) begin
      pc_write_en  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (freeze) begin
      // Whole pipe freezes; a pending branch or hazard re-presents afterwards.
      pc_write_en = 1'b0;
      if_id_hold  = 1'b1;
      id_ex_hold  = 1'b1;
      ex_mem_hold = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      icache_abort = (state == ST_IWAIT) || !icache_ready;
    end else if (load_use) begin
      pc_write_en  = 1'b0;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (fetch_wait) begin
      pc_write_en = 1'b0;
      if_id_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic branch_flush;
  logic lu_bubble;

  // Only a branch flushes with the PC advancing; only a load-use bubbles while holding.
  assign branch_flush = if_id_flush && pc_write_en;
  assign lu_bubble    = id_ex_bubble && if_id_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_load_use     <= '0;
    end else begin
      if (!pc_write_en) perf_stall_cycles <= perf_stall_cycles + WORD_SIZE'(1);
      if (branch_flush) perf_flushes      <= perf_flushes + WORD_SIZE'(1);
      if (lu_bubble)    perf_load_use     <= perf_load_use + WORD_SIZE'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences and randomized cycles against a behavioural reference model.
module tb_pipeline_hazard_controller;

  localparam int MEM_TIMEOUT = 8;
  localparam int WORD_SIZE   = 32;

  // Output vector order: pc_we, if_id_hold, if_id_flush, id_ex_hold,
  // id_ex_bubble, ex_mem_hold, icache_abort, timeout_err
  localparam logic [7:0] O_RESET  = 8'b0010_1000;
  localparam logic [7:0] O_RUN    = 8'b1000_0000;
  localparam logic [7:0] O_STALL  = 8'b0100_1000;
  localparam logic [7:0] O_BRANCH = 8'b1010_1000;
  localparam logic [7:0] O_FREEZE = 8'b0101_0100;
  localparam logic [7:0] O_IWAIT  = 8'b0010_0000;
  localparam logic [7:0] O_ABORT  = 8'b1010_1010;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       ir;
    logic       dq;
    logic       dr;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       icache_ready, dcache_req, dcache_ready;
  logic       pc_write_en, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
  logic       ex_mem_hold, icache_abort, timeout_err;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [WORD_SIZE-1:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: which wait the pipeline is in, how long, sticky error.
  bit m_dwait, m_iwait, m_err;
  int m_wait;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .WORD_SIZE   (WORD_SIZE),
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .icache_ready    (icache_ready),
    .dcache_req      (dcache_req),
    .dcache_ready    (dcache_ready),
    .pc_write_en     (pc_write_en),
    .if_id_hold      (if_id_hold),
    .if_id_flush     (if_id_flush),
    .id_ex_hold      (id_ex_hold),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .icache_abort    (icache_abort),
`ifdef HAZARD_PERF_COUNTERS_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_load_use     (perf_load_use),
`endif
    .timeout_err     (timeout_err)
  );

  function automatic logic [7:0] outs();
    return {pc_write_en, if_id_hold, if_id_flush, id_ex_hold,
            id_ex_bubble, ex_mem_hold, icache_abort, timeout_err};
  endfunction

  function automatic in_t idle();
    in_t v;
    v     = '0;
    v.rst = 1'b1;
    v.ir  = 1'b1;
    v.dr  = 1'b1;
    return v;
  endfunction

  // Expected outputs straight from the priority rules.
  function automatic logic [7:0] model_out(input in_t v);
    bit hz;
    bit frozen;
    bit fetch_stall;
    hz = v.mr && (v.rd != 0) &&
         ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    frozen      = m_dwait || (!m_iwait && v.dq && !v.dr);
    fetch_stall = m_iwait || (!m_dwait && !v.ir);
    if (!v.rst)     return O_RESET;
    if (frozen)     return O_FREEZE | {7'b0, m_err};
    if (v.br)       return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, (m_iwait || !v.ir), m_err};
    if (hz)         return O_STALL | {7'b0, m_err};
    if (fetch_stall) return O_IWAIT | {7'b0, m_err};
    return O_RUN | {7'b0, m_err};
  endfunction

  task automatic model_tick(input in_t v);
    bit was_waiting;
    if (!v.rst) begin
      m_dwait = 0; m_iwait = 0; m_wait = 0; m_err = 0;
      return;
    end
    was_waiting = m_dwait || m_iwait;
    if (m_dwait)      m_dwait = !v.dr;
    else if (m_iwait) m_iwait = !(v.ir || v.br);
    else begin
      m_dwait = v.dq && !v.dr;
      m_iwait = !m_dwait && !v.ir;
    end
    if (!(m_dwait || m_iwait)) m_wait = 0;
    else if (was_waiting) begin
      if (m_wait < MEM_TIMEOUT) m_wait++;
      if (m_wait == MEM_TIMEOUT) m_err = 1;
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    rst_n           = v.rst;
    id_rs1          = v.rs1;
    id_rs2          = v.rs2;
    id_uses_rs1     = v.u1;
    id_uses_rs2     = v.u2;
    ex_rd           = v.rd;
    ex_mem_read     = v.mr;
    ex_branch_taken = v.br;
    icache_ready    = v.ir;
    dcache_req      = v.dq;
    dcache_ready    = v.dr;
  endtask

  // One clock: drive just after posedge, compare at negedge, advance model at posedge.
  task automatic cycle(input string name, input in_t v, input logic [7:0] exp);
    drive(v);
    @(negedge clk);
    check(name, outs(), exp);
    @(posedge clk);
    model_tick(v);
    #1;
  endtask

  task automatic cycle_model(input string name, input in_t v);
    drive(v);
    @(negedge clk);
    check(name, outs(), model_out(v));
    @(posedge clk);
    model_tick(v);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    in_t v;
    vec_t e;

    // Directed single-cycle vectors, all of which leave the FSM in RUN.
    v = idle();                                    e = '{"idle", v, O_RUN};                 tbl.push_back(e);
    v = idle(); v.mr = 1; v.rd = 5; v.rs1 = 5; v.u1 = 1;
                                                   e = '{"lu_rs1", v, O_STALL};             tbl.push_back(e);
    v.rd = 0; v.rs1 = 0;                           e = '{"lu_rd0", v, O_RUN};               tbl.push_back(e);
    v = idle(); v.mr = 1; v.rd = 7; v.rs2 = 7;     e = '{"rs2_unused", v, O_RUN};           tbl.push_back(e);
    v.u2 = 1;                                      e = '{"lu_rs2", v, O_STALL};             tbl.push_back(e);
    v.mr = 0;                                      e = '{"no_load", v, O_RUN};              tbl.push_back(e);
    v = idle(); v.mr = 1; v.rd = 5; v.rs1 = 5; v.u1 = 1; v.br = 1;
                                                   e = '{"branch_vs_lu", v, O_BRANCH};      tbl.push_back(e);
    v = idle(); v.br = 1;                          e = '{"branch", v, O_BRANCH};            tbl.push_back(e);
    v = idle(); v.dq = 1; v.dr = 1;                e = '{"dcache_hit", v, O_RUN};           tbl.push_back(e);
    v = idle(); v.mr = 1; v.rd = 31; v.rs1 = 31; v.rs2 = 31; v.u1 = 1; v.u2 = 1;
                                                   e = '{"lu_both_r31", v, O_STALL};        tbl.push_back(e);

    // Reset held for three cycles, then released with the I-cache ready.
    m_dwait = 0; m_iwait = 0; m_wait = 0; m_err = 0;
    v = idle(); v.rst = 0;
    drive(v);
    #1;
    for (int i = 0; i < 3; i++) cycle("reset", v, O_RESET);
    cycle("post_reset", idle(), O_RUN);

    foreach (tbl[i]) cycle(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Single-cycle stall: the hazard clears once the load moves on.
    v = idle(); v.mr = 1; v.rd = 5; v.rs1 = 5; v.u1 = 1;
    cycle("lu_stall", v, O_STALL);
    cycle("lu_clear", idle(), O_RUN);

    // D-cache miss with a branch arriving mid-freeze: full freeze, no flush.
    v = idle(); v.dq = 1; v.dr = 0;
    cycle("dmiss_enter", v, O_FREEZE);
    v.br = 1;
    for (int i = 0; i < 3; i++) cycle("dmiss_branch_deferred", v, O_FREEZE);
    v.dr = 1;
    cycle("dmiss_done", v, O_FREEZE);
    cycle("dmiss_run", idle(), O_RUN);

    // I-cache miss resolved by a redirect: one abort pulse, then back to RUN.
    v = idle(); v.ir = 0;
    cycle("imiss_enter", v, O_IWAIT);
    cycle("imiss_wait", v, O_IWAIT);
    v.br = 1;
    cycle("imiss_redirect", v, O_ABORT);
    cycle("imiss_run", idle(), O_RUN);

    // Watchdog: the tenth cycle of the miss sees the counter at the limit.
    v = idle(); v.dq = 1; v.dr = 0;
    for (int i = 0; i < 10; i++)
      cycle($sformatf("wd_wait%0d", i), v, O_FREEZE | {7'b0, (i >= 9)});
    v.dr = 1;
    cycle("wd_exit", v, O_FREEZE | 8'b1);
    cycle("wd_sticky", idle(), O_RUN | 8'b1);
    cycle("wd_sticky2", idle(), O_RUN | 8'b1);
    v = idle(); v.rst = 0;
    cycle("wd_reset", v, O_RESET);
    cycle("wd_cleared", idle(), O_RUN);

    // Reset in the middle of an I-cache wait: no abort, straight to RUN.
    v = idle(); v.ir = 0;
    cycle("imiss_pre_rst", v, O_IWAIT);
    v.rst = 0; v.br = 1;
    cycle("imiss_rst", v, O_RESET);
    cycle("imiss_rst_run", idle(), O_RUN);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      v.rst = ($urandom_range(0, 149) != 0);
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1  = 1'($urandom_range(0, 1));
      v.u2  = 1'($urandom_range(0, 1));
      v.mr  = 1'($urandom_range(0, 1));
      v.br  = ($urandom_range(0, 5) == 0);
      v.ir  = ($urandom_range(0, 7) != 0);
      v.dq  = ($urandom_range(0, 2) == 0);
      v.dr  = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 4) != 0);
      cycle_model("random", v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
